seq_alu: RTL and testbench

Parametrised, registered ALU for the MIPS datapath. It generalises the 32-bit ripple ALU to any `WIDTH` and adds XOR/NOR and a corrected signed SLT. It also adds an iterative unsigned multiplier that produces a 2×WIDTH product over WIDTH cycles. Operations are launched by a start/busy/done handshake, so the controller stalls only on multiply.

---
 rtl/seq_alu.sv | 148 ++++++++++++++
 tb/tb_seq_alu.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Registered ALU with start/busy/done handshake; single-cycle logic ops and
// add/sub/slt, plus an iterative shift-add unsigned multiplier (WIDTH cycles).
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_MULU = 4'b1000;

  localparam logic STATE_IDLE = 1'b0;
  localparam logic STATE_MUL  = 1'b1;

  localparam int CW = $clog2(WIDTH + 1);

  logic               state_r;
  logic [CW-1:0]      cnt_r;
  logic [WIDTH-1:0]   mcand_r;
  logic [2*WIDTH-1:0] acc_r;

  logic [WIDTH-1:0]   b_eff_s;
  logic               cin_s;
  logic [WIDTH:0]     sum_s;
  logic               add_ovf_s;
  logic [WIDTH-1:0]   alu_res_s;
  logic               alu_ovf_s;
  logic               alu_carry_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [2*WIDTH-1:0] acc_next_s;

  // Shared adder: ADD uses a+b, SUB and SLT use a+~b+1.
  always_comb begin
    if (op == OP_ADD) begin
      b_eff_s = b;
      cin_s   = 1'b0;
    end else begin
      b_eff_s = ~b;
      cin_s   = 1'b1;
    end
    sum_s     = {1'b0, a} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, cin_s};
    add_ovf_s = (a[WIDTH-1] == b_eff_s[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
  end

  // Single-cycle result and flag selection.
  always_comb begin
    alu_res_s   = {WIDTH{1'b0}};
    alu_ovf_s   = 1'b0;
    alu_carry_s = 1'b0;
    case (op)
      OP_AND: alu_res_s = a & b;
      OP_OR:  alu_res_s = a | b;
      OP_XOR: alu_res_s = a ^ b;
      OP_NOR: alu_res_s = ~(a | b);
      OP_ADD, OP_SUB: begin
        alu_res_s   = sum_s[WIDTH-1:0];
        alu_ovf_s   = add_ovf_s;
        alu_carry_s = sum_s[WIDTH];
      end
      // Sign XOR overflow gives the true signed less-than even when a-b wraps.
      OP_SLT: alu_res_s = {{(WIDTH-1){1'b0}}, sum_s[WIDTH-1] ^ add_ovf_s};
      default: alu_res_s = {WIDTH{1'b0}};
    endcase
  end

  // One shift-add step; the multiplier sits in the low half and drains out bit 0.
  always_comb begin
    if (acc_r[0]) begin
      mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, mcand_r};
    end else begin
      mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
    end
    acc_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
  end

  // Control FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= STATE_IDLE;
      cnt_r     <= {CW{1'b0}};
      mcand_r   <= {WIDTH{1'b0}};
      acc_r     <= {(2*WIDTH){1'b0}};
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= {WIDTH{1'b0}};
      result_hi <= {WIDTH{1'b0}};
      zero      <= 1'b1;
      overflow  <= 1'b0;
      carry_out <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        STATE_IDLE: begin
          if (start) begin
            if (op == OP_MULU) begin
              mcand_r <= a;
              acc_r   <= {{WIDTH{1'b0}}, b};
              cnt_r   <= CW'(WIDTH);
              busy    <= 1'b1;
              state_r <= STATE_MUL;
            end else begin
              result    <= alu_res_s;
              result_hi <= {WIDTH{1'b0}};
              zero      <= (alu_res_s == {WIDTH{1'b0}});
              overflow  <= alu_ovf_s;
              carry_out <= alu_carry_s;
              done      <= 1'b1;
            end
          end
        end
        STATE_MUL: begin
          acc_r <= acc_next_s;
          cnt_r <= cnt_r - CW'(1);
          if (cnt_r == CW'(1)) begin
            result    <= acc_next_s[WIDTH-1:0];
            result_hi <= acc_next_s[2*WIDTH-1:WIDTH];
            zero      <= (acc_next_s[WIDTH-1:0] == {WIDTH{1'b0}});
            overflow  <= 1'b0;
            carry_out <= 1'b0;
            done      <= 1'b1;
            busy      <= 1'b0;
            state_r   <= STATE_IDLE;
          end
        end
        default: state_r <= STATE_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: a 32-bit and an 8-bit instance, fixed vectors, corner
// sequences (reset, mid-multiply start/reset, back-to-back) and random ops.
module tb_seq_alu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start32, busy32, done32, z32, ov32, c32;
  logic [3:0]  op32;
  logic [31:0] a32, b32, res32, hi32;
  logic        start8, busy8, done8, z8, ov8, c8;
  logic [3:0]  op8;
  logic [7:0]  a8, b8, res8, hi8;

  int checks = 0;
  int errors = 0;

  seq_alu #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .op(op32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .result(res32), .result_hi(hi32),
    .zero(z32), .overflow(ov32), .carry_out(c32)
  );

  seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(res8), .result_hi(hi8),
    .zero(z8), .overflow(ov8), .carry_out(c8)
  );

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] hi;
    logic        z;
    logic        ov;
    logic        c;
  } exp_t;

  typedef struct packed {
    logic done;
    logic busy;
    exp_t e;
  } obs_t;

  typedef struct {
    int          w;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    exp_t        e;
  } vec_t;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(logic [31:0] res, logic [31:0] hi, logic z, logic ov, logic c);
    exp_t e;
    e.res = res; e.hi = hi; e.z = z; e.ov = ov; e.c = c;
    return e;
  endfunction

  // Reference model from plain integer arithmetic on w-bit values.
  function automatic exp_t model(int w, logic [3:0] op, logic [31:0] a_in, logic [31:0] b_in);
    longint unsigned mask, a, b, u;
    longint sa, sb, t, smax, smin;
    exp_t e;
    mask = (64'd1 << w) - 64'd1;
    a = {32'd0, a_in} & mask;
    b = {32'd0, b_in} & mask;
    smax = longint'((64'd1 << (w - 1)) - 64'd1);
    smin = -smax - 64'sd1;
    sa = a[w-1] ? longint'(a) - longint'(64'd1 << w) : longint'(a);
    sb = b[w-1] ? longint'(b) - longint'(64'd1 << w) : longint'(b);
    e = '0;
    u = 64'd0;
    case (op)
      4'b0000: u = a & b;
      4'b0001: u = a | b;
      4'b0011: u = a ^ b;
      4'b1100: u = ~(a | b) & mask;
      4'b0010: begin
        u = a + b;
        e.c = ((u >> w) != 64'd0);
        t = sa + sb;
        e.ov = (t > smax) || (t < smin);
      end
      4'b0110: begin
        u = a - b;
        e.c = (a >= b);
        t = sa - sb;
        e.ov = (t > smax) || (t < smin);
      end
      4'b0111: u = (sa < sb) ? 64'd1 : 64'd0;
      4'b1000: begin
        u = a * b;
        e.hi = 32'(u >> w);
      end
      default: u = 64'd0;
    endcase
    e.res = 32'(u & mask);
    e.z = (e.res == 32'd0);
    return e;
  endfunction

  task automatic drive(int w, logic s, logic [3:0] op, logic [31:0] a, logic [31:0] b);
    if (w == 32) begin
      start32 = s; op32 = op; a32 = a; b32 = b;
    end else begin
      start8 = s; op8 = op; a8 = a[7:0]; b8 = b[7:0];
    end
  endtask

  function automatic obs_t sample(int w);
    obs_t o;
    if (w == 32) begin
      o.done = done32; o.busy = busy32;
      o.e = mk(res32, hi32, z32, ov32, c32);
    end else begin
      o.done = done8; o.busy = busy8;
      o.e = mk({24'd0, res8}, {24'd0, hi8}, z8, ov8, c8);
    end
    return o;
  endfunction

  task automatic check_out(string tag, obs_t o, exp_t e);
    chk({tag, " result"}, o.e.res, e.res);
    chk({tag, " result_hi"}, o.e.hi, e.hi);
    chk({tag, " zero"}, 32'(o.e.z), 32'(e.z));
    chk({tag, " overflow"}, 32'(o.e.ov), 32'(e.ov));
    chk({tag, " carry_out"}, 32'(o.e.c), 32'(e.c));
  endtask

  // Issue one op, wait for done with a bound, check latency, busy span, outputs, pulse width.
  task automatic do_op(string tag, int w, logic [3:0] op, logic [31:0] a, logic [31:0] b, exp_t e);
    obs_t o;
    int k, bc, lat;
    drive(w, 1'b0, op, a, b);
    drive(w, 1'b1, op, a, b);
    @(posedge clk); #1;
    drive(w, 1'b0, 4'($urandom), $urandom, $urandom);
    k = 0; bc = 0;
    o = sample(w);
    while (!o.done && k < 200) begin
      if (o.busy) bc++;
      @(posedge clk); #1;
      k++;
      o = sample(w);
    end
    lat = (op == 4'b1000) ? w : 0;
    chk({tag, " latency"}, 32'(k), 32'(lat));
    chk({tag, " busy cycles"}, 32'(bc), 32'(lat));
    chk({tag, " busy at done"}, 32'(o.busy), 32'd0);
    check_out(tag, o, e);
    @(posedge clk); #1;
    o = sample(w);
    chk({tag, " done width"}, 32'(o.done), 32'd0);
  endtask

  vec_t vecs[16];
  logic [31:0] edge_vals[7];
  logic [3:0]  op_list[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t o;
    int k, dn, w;
    logic [3:0] op;
    logic [31:0] a, b;

    vecs[0]  = '{32, 4'b0010, 32'h7FFFFFFF, 32'h00000001, mk(32'h80000000, 32'h0, 1'b0, 1'b1, 1'b0)};
    vecs[1]  = '{32, 4'b0110, 32'h00000005, 32'h00000005, mk(32'h00000000, 32'h0, 1'b1, 1'b0, 1'b1)};
    vecs[2]  = '{32, 4'b0010, 32'hFFFFFFFF, 32'h00000001, mk(32'h00000000, 32'h0, 1'b1, 1'b0, 1'b1)};
    vecs[3]  = '{32, 4'b0111, 32'h80000000, 32'h00000001, mk(32'h00000001, 32'h0, 1'b0, 1'b0, 1'b0)};
    vecs[4]  = '{32, 4'b0111, 32'h00000001, 32'h80000000, mk(32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0)};
    vecs[5]  = '{32, 4'b0000, 32'hF0F0F0F0, 32'h0FF00FF0, mk(32'h00F000F0, 32'h0, 1'b0, 1'b0, 1'b0)};
    vecs[6]  = '{32, 4'b0001, 32'hF0F0F0F0, 32'h0FF00FF0, mk(32'hFFF0FFF0, 32'h0, 1'b0, 1'b0, 1'b0)};
    vecs[7]  = '{32, 4'b0011, 32'hF0F0F0F0, 32'h0FF00FF0, mk(32'hFF00FF00, 32'h0, 1'b0, 1'b0, 1'b0)};
    vecs[8]  = '{32, 4'b1100, 32'hF0F0F0F0, 32'h0FF00FF0, mk(32'h000F000F, 32'h0, 1'b0, 1'b0, 1'b0)};
    vecs[9]  = '{32, 4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, mk(32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0)};
    vecs[10] = '{32, 4'b0110, 32'h00000003, 32'h00000005, mk(32'hFFFFFFFE, 32'h0, 1'b0, 1'b0, 1'b0)};
    vecs[11] = '{32, 4'b0110, 32'h80000000, 32'h00000001, mk(32'h7FFFFFFF, 32'h0, 1'b0, 1'b1, 1'b1)};
    vecs[12] = '{8,  4'b1000, 32'h000000C8, 32'h00000003, mk(32'h00000058, 32'h02, 1'b0, 1'b0, 1'b0)};
    vecs[13] = '{8,  4'b0010, 32'h0000007F, 32'h00000001, mk(32'h00000080, 32'h0, 1'b0, 1'b1, 1'b0)};
    vecs[14] = '{8,  4'b0101, 32'h00000012, 32'h00000034, mk(32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0)};
    vecs[15] = '{8,  4'b0111, 32'h00000080, 32'h00000001, mk(32'h00000001, 32'h0, 1'b0, 1'b0, 1'b0)};

    edge_vals = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h80, 32'h7F, 32'h1};
    op_list = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0110, 4'b0111, 4'b1100, 4'b1000};

    // Reset held two cycles with start asserted: the op must not execute.
    reset = 1'b1;
    drive(32, 1'b1, 4'b0010, 32'h1, 32'h1);
    drive(8, 1'b1, 4'b0010, 32'h1, 32'h1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    drive(32, 1'b0, 4'b0000, 32'h0, 32'h0);
    drive(8, 1'b0, 4'b0000, 32'h0, 32'h0);
    o = sample(32);
    check_out("reset32", o, mk(32'h0, 32'h0, 1'b1, 1'b0, 1'b0));
    chk("reset32 busy", 32'(o.busy), 32'd0);
    chk("reset32 done", 32'(o.done), 32'd0);
    o = sample(8);
    check_out("reset8", o, mk(32'h0, 32'h0, 1'b1, 1'b0, 1'b0));
    chk("reset8 busy", 32'(o.busy), 32'd0);
    @(posedge clk); #1;
    chk("reset32 start dropped", 32'(done32), 32'd0);
    chk("reset8 start dropped", 32'(done8), 32'd0);

    for (int i = 0; i < 16; i++)
      do_op($sformatf("vec%0d", i), vecs[i].w, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].e);

    // Start+ADD issued mid-multiply must be ignored.
    drive(32, 1'b1, 4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF);
    @(posedge clk); #1;
    drive(32, 1'b0, 4'b1000, 32'h0, 32'h0);
    repeat (5) @(posedge clk);
    #1;
    drive(32, 1'b1, 4'b0010, 32'h1, 32'h2);
    @(posedge clk); #1;
    drive(32, 1'b0, 4'b0010, 32'h1, 32'h2);
    chk("midmul busy", 32'(busy32), 32'd1);
    k = 6;
    while (!done32 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    chk("midmul latency", 32'(k), 32'd32);
    check_out("midmul", sample(32), mk(32'h1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0));
    dn = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (done32) dn++;
    end
    chk("midmul extra done", 32'(dn), 32'd0);

    // Reset at iteration 10 of a multiply: abort, no done, reset values.
    drive(32, 1'b1, 4'b1000, 32'hFFFFFFFF, 32'h3);
    @(posedge clk); #1;
    drive(32, 1'b0, 4'b0000, 32'h0, 32'h0);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    o = sample(32);
    check_out("midreset", o, mk(32'h0, 32'h0, 1'b1, 1'b0, 1'b0));
    chk("midreset busy", 32'(o.busy), 32'd0);
    chk("midreset done", 32'(o.done), 32'd0);
    dn = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done32) dn++;
    end
    chk("midreset no done", 32'(dn), 32'd0);

    // Four single-cycle ops on consecutive cycles.
    for (int i = 0; i < 4; i++) begin
      drive(32, 1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
      @(posedge clk); #1;
      o = sample(32);
      chk($sformatf("b2b%0d done", i), 32'(o.done), 32'd1);
      check_out($sformatf("b2b%0d", i), o, model(32, vecs[i].op, vecs[i].a, vecs[i].b));
    end
    drive(32, 1'b0, 4'b0000, 32'h0, 32'h0);
    @(posedge clk); #1;
    chk("b2b done end", 32'(done32), 32'd0);

    // Random ops against the model.
    for (int n = 0; n < 60; n++) begin
      w = ($urandom_range(0, 1) == 0) ? 32 : 8;
      if ($urandom_range(0, 9) >= 8) op = 4'($urandom);
      else op = op_list[$urandom_range(0, 7)];
      a = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 6)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 6)] : $urandom;
      do_op($sformatf("rnd%0d w%0d op%0h", n, w, op), w, op, a, b, model(w, op, a, b));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
